// File: rtl/gp_cmd_sequencer.sv
// GP command sequencer: fetches each 64-bit command as two buffer words, decodes it and
// dispatches it over valid/ready. Define GP_SEQ_TIMEOUT_EN to add the read-data watchdog.
module gp_cmd_sequencer #(
    parameter int CMD_WIDTH  = 32,
    parameter int IDX_WIDTH  = 8,
    parameter int MAX_CMDS   = 128,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [IDX_WIDTH-1:0] start_idx,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic [IDX_WIDTH-1:0] cmd_cnt,
    output logic                 cmd_rd_en,
    output logic [IDX_WIDTH-1:0] cmd_addr,
    input  logic                 cmd_rd_valid,
    input  logic [CMD_WIDTH-1:0] cmd_out,
    output logic                 exe_valid,
    input  logic                 exe_ready,
    output logic [3:0]           exe_op,
    output logic [27:0]          exe_addr,
    output logic [31:0]          exe_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_W0, S_F1, S_W1, S_DEC, S_DISP, S_ADV, S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_WRITE = 4'h1,
        OP_READ  = 4'h2,
        OP_END   = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_OPCODE  = 2'd1,
        ERR_LIMIT   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] IDX_TWO = IDX_WIDTH'(2);
    localparam logic [IDX_WIDTH-1:0] CNT_MAX = IDX_WIDTH'(MAX_CMDS);

    state_e               state;
    logic [IDX_WIDTH-1:0] ptr;
    logic [CMD_WIDTH-1:0] word0;
    logic [CMD_WIDTH-1:0] word1;
    logic [3:0]           dec_op;
    logic                 tmo_hit;

    assign dec_op = word0[CMD_WIDTH-1 -: 4];

`ifdef GP_SEQ_TIMEOUT_EN
    localparam int TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             rd_waiting;

    assign rd_waiting = (state == S_W0 || state == S_W1) && !cmd_rd_valid;

    // Held at zero outside W0/W1, so every entry into a wait state starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (rd_waiting && !abort) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = rd_waiting && (tmo_cnt == TMO_LAST);
`else
    logic unused_rd_timeout;

    assign unused_rd_timeout = ^RD_TIMEOUT;
    assign tmo_hit           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cmd_cnt   <= '0;
            err       <= ERR_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_rd_en <= 1'b0;
            cmd_addr  <= '0;
            exe_valid <= 1'b0;
            exe_op    <= '0;
            exe_addr  <= '0;
            exe_data  <= '0;
            word0     <= '0;
            word1     <= '0;
        end else begin
            // NOTE: outputs are registered, so each transition loads the values the next state presents.
            cmd_rd_en <= 1'b0;
            done      <= 1'b0;

            if (abort && state != S_IDLE && state != S_DONE) begin
                exe_valid <= 1'b0;
                done      <= 1'b1;
                state     <= S_DONE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            ptr       <= start_idx;
                            cmd_cnt   <= '0;
                            err       <= ERR_NONE;
                            busy      <= 1'b1;
                            cmd_rd_en <= 1'b1;
                            cmd_addr  <= start_idx;
                            state     <= S_F0;
                        end
                    end
                    S_F0: state <= S_W0;
                    S_W0: begin
                        if (cmd_rd_valid) begin
                            word0     <= cmd_out;
                            cmd_rd_en <= 1'b1;
                            cmd_addr  <= ptr + IDX_ONE;
                            state     <= S_F1;
                        end else if (tmo_hit) begin
                            err   <= ERR_TIMEOUT;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_F1: state <= S_W1;
                    S_W1: begin
                        if (cmd_rd_valid) begin
                            word1 <= cmd_out;
                            state <= S_DEC;
                        end else if (tmo_hit) begin
                            err   <= ERR_TIMEOUT;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_DEC: begin
                        case (dec_op)
                            OP_END: begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                            OP_NOP: state <= S_ADV;
                            OP_WRITE, OP_READ: begin
                                exe_valid <= 1'b1;
                                exe_op    <= dec_op;
                                exe_addr  <= word0[27:0];
                                exe_data  <= word1[31:0];
                                state     <= S_DISP;
                            end
                            default: begin
                                err   <= ERR_OPCODE;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        endcase
                    end
                    S_DISP: begin
                        if (exe_ready) begin
                            exe_valid <= 1'b0;
                            cmd_cnt   <= cmd_cnt + IDX_ONE;
                            state     <= S_ADV;
                        end
                    end
                    S_ADV: begin
                        ptr <= ptr + IDX_TWO;
                        if (cmd_cnt == CNT_MAX) begin
                            err   <= ERR_LIMIT;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cmd_rd_en <= 1'b1;
                            cmd_addr  <= ptr + IDX_TWO;
                            state     <= S_F0;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/gp_cmd_sequencer.md
# gp_cmd_sequencer

Command sequencer for the GP engine. It walks the command buffer from a programmed start index and fetches each 64-bit command as two consecutive 32-bit words. Each command is decoded and dispatched to the execution engine over a valid/ready handshake. It sits between the command buffer's FSM read port and the execution datapath, and is the only master of that read port.

## Interface
- CMD_WIDTH, 32: width of one command-buffer word.
- IDX_WIDTH, 8: command-buffer index width (256 words).
- MAX_CMDS, 128: runaway limit, i.e. the maximum number of commands per run.
- RD_TIMEOUT, 16: cycles to wait for read data before error (only used with GP_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  sole clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy.
- abort  in  1  level; terminates the run.
- start_idx  in  IDX_WIDTH  word index of the first command, sampled on start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when a run ends (END, error or abort).
- err  out  2  sticky until the next start: 0 none, 1 bad opcode, 2 limit reached, 3 read timeout.
- cmd_cnt  out  IDX_WIDTH  number of commands dispatched in the current or last run.
- cmd_rd_en  out  1  one-cycle read strobe to the command buffer.
- cmd_addr  out  IDX_WIDTH  word index for the read.
- cmd_rd_valid  in  1  read data valid.
- cmd_out  in  CMD_WIDTH  read data.
- exe_valid  out  1  command available.
- exe_ready  in  1  execution engine accepts.
- exe_op  out  4  opcode.
- exe_addr  out  28  word0[27:0].
- exe_data  out  32  word1.

## Operation
- Command format: word0 = {opcode[31:28], addr[27:0]}, word1 = data.
  - Opcodes: 0x0 NOP, 0x1 WRITE, 0x2 READ, 0xF END. Any other opcode is an error.
- States:
  - IDLE -> F0 on start. On that transition ptr is loaded from start_idx, and cnt and err are cleared.
  - F0: assert cmd_rd_en with cmd_addr=ptr -> W0.
  - W0: wait for cmd_rd_valid and latch word0 -> F1.
  - F1: assert cmd_rd_en with cmd_addr=ptr+1 -> W1.
  - W1: wait for cmd_rd_valid and latch word1 -> DEC.
  - DEC:
    - END -> DONE.
    - NOP -> ADV.
    - WRITE or READ -> DISP.
    - Any other opcode: err=1 -> DONE.
  - DISP: hold exe_valid and the exe_* fields stable until exe_ready. On that cycle cnt+1 -> ADV.
  - ADV: ptr += 2.
    - If cnt == MAX_CMDS: err=2 -> DONE.
    - Otherwise -> F0.
  - DONE: pulse done -> IDLE.
- Index arithmetic is modulo 2^IDX_WIDTH.
  - ptr+1 and ptr+2 wrap silently; for example index 255 is followed by 0.
  - The 32-bit word1 index is truncated to IDX_WIDTH.
- NOP and END are not counted and not dispatched.
- abort in any state other than IDLE or DONE goes to DONE next cycle with err unchanged. An outstanding cmd_rd_valid that arrives later is ignored.
- cmd_rd_valid outside W0/W1 is ignored.
- start coincident with abort in IDLE: start wins, and abort is evaluated from F0 onward.

## Timing
- Reset: every output is 0, state is IDLE, and ptr/cnt/err are 0. Reset in mid-run discards the run with no done pulse.
- cmd_rd_en is high for exactly one cycle per word. It is never re-issued until the data has returned.
- With a 1-cycle buffer latency and exe_ready held high, a dispatched command costs 6 cycles (F0, W0, F1, W1, DEC, DISP) plus 1 for ADV.
  - exe_valid rises 5 cycles after the F0 cycle.
- With start in cycle 0: busy is high in cycle 1 and F0's cmd_rd_en is in cycle 1.
- exe_* outputs change only on entry to DISP. exe_valid drops the cycle after the exe_ready handshake.
- done coincides with the busy high-to-low transition: done is high for one cycle and busy is low in the following cycle.

## Configuration
- GP_SEQ_TIMEOUT_EN defined:
  - A counter runs in W0/W1 and reloads on each entry.
  - After RD_TIMEOUT cycles without cmd_rd_valid: err=3 -> DONE.
- Not defined: no counter is present, W0/W1 wait indefinitely, and err never equals 3.

## Test plan
- Buffer holds [0]=0x1000_0040, [1]=0xDEAD_BEEF, [2]=0xF000_0000. Start with start_idx=0 and exe_ready=1 -> one dispatch: op=1, addr=0x40, data=0xDEADBEEF. Then done, err=0, cmd_cnt=1.
- Same program with exe_ready held low for 10 cycles -> exe_valid and exe_* stay stable for 11 cycles. Exactly one handshake occurs and cmd_cnt=1.
- Program placed at idx 254/255 with END at 0/1, start_idx=254 -> reads addresses 254, 255, 0, 1. Result: cmd_cnt=1, err=0.
- word0=0x7000_0000 -> no exe_valid, done pulse, err=1. A NOP at [0..1] followed by END gives cmd_cnt=0.
- 256 words of WRITE with no END and MAX_CMDS=128 -> 128 handshakes, then err=2 and done.
- With GP_SEQ_TIMEOUT_EN and cmd_rd_valid never returned -> err=3 after 16 cycles in W0. A separate check: abort asserted in DISP -> done the next cycle, and cmd_cnt is unchanged.
